uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
Parametrised UART receiver, next generation of the team's fixed 8-bit even-parity receiver. Adds configurable data width, parity mode (none/even/odd) and stop-bit count, plus an oversampled baud tick, a 2-FF input synchroniser, false-start rejection, and framing and overrun detection. Output is a valid/ack handshake toward the host-side register block or FIFO.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- PARITY_MODE, 1, 0 = none, 1 = even, 2 = odd.
- STOP_BITS, 1, stop bits checked; 1 or 2.
- OVERSAMPLE, 16, baud ticks per bit; even, >= 8.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idles high.
- data  out  DATA_BITS  received word, LSB = first bit received.
- rx_valid  out  1  data, parity_error and framing_error are valid; held high until acknowledged.
- rx_ack  in  1  consumer accepts the word; sampled only while rx_valid = 1.
- parity_error  out  1  parity mismatch in the held frame; 0 when PARITY_MODE = 0.
- framing_error  out  1  a stop bit was sampled low in the held frame.
- overrun_error  out  1  sticky; a frame was dropped because rx_valid was still high.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Only clk is used. Reset is synchronous and active-high.
- Reset values: data = 0, rx_valid = 0, all error flags = 0, busy = 0, state = IDLE, synchroniser = 2'b11. Reset mid-frame aborts the frame and discards any partial word.
- Synchroniser: rx passes through 2 flops (rx_s); all logic uses rx_s.
- Tick generator: TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE). The counter produces a 1-clk tick every TICK_DIV clks. It runs freely and resynchronises to 0 on start-bit detection.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - A falling edge on rx_s (1 then 0) moves to START.
  - The tick counter and the sample counter clear.
- START:
  - At tick OVERSAMPLE/2 - 1, rx_s is sampled.
  - rx_s = 1 is a false start: return to IDLE with no flags set.
  - rx_s = 0: go to DATA, bit index = 0.
- DATA:
  - Each bit is sampled at the midpoint, i.e. every OVERSAMPLE ticks after the start-bit midpoint.
  - Bits shift in LSB first.
  - After bit DATA_BITS-1, go to PARITY if PARITY_MODE != 0, else to STOP.
- PARITY:
  - Sample one bit.
  - Expected value: even = XOR of all data bits; odd = inverse of that XOR.
  - Mismatch sets an internal perr.
- STOP:
  - Sample STOP_BITS bits. Any low sample sets an internal ferr.
  - At the midpoint of the last stop bit, the frame completes and the state returns to IDLE. There is no wait for the end of the bit, so back-to-back frames are received.
- Frame completion:
  - If rx_valid = 0, or rx_ack = 1 in the same cycle: load data, parity_error = perr and framing_error = ferr; rx_valid = 1 on the next clk.
  - Otherwise drop the frame, keep the old word and flags, and set overrun_error.
- Ack:
  - rx_ack = 1 while rx_valid = 1 clears rx_valid on the next clk, unless a new frame loads in the same cycle.
  - rx_ack = 1 while rx_valid = 0 is ignored.
- Frames with a framing error are still delivered, with framing_error = 1.
- overrun_error clears only on reset.
- Latency: rx_valid rises 3 clks after the last-stop-bit midpoint seen on rx (2 synchroniser flops + 1 output register).
- Counter widths: each counter is sized with $clog2 of its maximum value. TICK_DIV < 1 is illegal; elaboration fails via a generate-time check.

Optional Feature:
UART_RX_MAJORITY_EN.
- Defined: every sample point (start, data, parity, stop) takes 3 samples of rx_s, at ticks mid-1, mid and mid+1, and uses the 2-of-3 majority. A single-tick glitch at mid is rejected.
- Undefined: a single sample at tick mid. A glitch at mid corrupts that bit.

Test Plan:
Common setup: CLK_FREQ = 16000000, BAUD_RATE = 1000000, OVERSAMPLE = 16, so TICK_DIV = 1 and one bit = 16 clks.
- DATA_BITS = 8, even parity, send 0xA5 with parity 0 and 1 stop bit, rx_ack held 0 -> data = 0xA5, rx_valid = 1, parity_error = 0, framing_error = 0. rx_valid stays high until rx_ack; it drops 1 clk after rx_ack.
- Odd parity, send 0x3C with parity bit 1 -> parity_error = 0. Repeat with parity bit 0 -> parity_error = 1, data = 0x3C still delivered.
- Send 0x55 with the stop bit driven low -> framing_error = 1, rx_valid = 1. Then send 0x0F with a good frame and ack the first word -> framing_error = 0.
- Send a 5-clk low pulse on an idle line -> no rx_valid, busy returns to 0 within 10 clks, no error flags set.
- Send 0x11 then 0x22 back-to-back, no ack -> data = 0x11, overrun_error = 1. Repeat with rx_ack pulsed in the completion cycle of 0x22 -> data = 0x22, overrun_error unchanged.
- Assert reset mid-DATA of 0xFF, release it, then send 0x81 -> data = 0x81 with no residue from the aborted frame. With UART_RX_MAJORITY_EN defined, a 1-clk glitch at the bit-3 midpoint of 0x81 leaves data = 0x81.

Source files
------------

// File: rtl/uart_rx_param.sv
// uart_rx_param
//   Parametrised UART receiver: configurable data width, parity (none/even/odd),
//   one or two stop bits, oversampled baud tick, 2-FF input synchroniser,
//   false-start rejection, framing and overrun detection, valid/ack output.
//
// Ports
//   clk            in   system clock
//   reset          in   synchronous, active-high reset
//   rx             in   asynchronous serial line, idles high
//   data           out  received word, LSB = first bit on the line
//   rx_valid       out  data/parity_error/framing_error valid, held until rx_ack
//   rx_ack         in   consumer accepts the held word (ignored while rx_valid = 0)
//   parity_error   out  parity mismatch in the held frame
//   framing_error  out  a stop bit was sampled low in the held frame
//   overrun_error  out  sticky: a frame was dropped while rx_valid was high
//   busy           out  high whenever the receiver is not in IDLE
//
// Build option
//   UART_RX_MAJORITY_EN  when defined, every sample point uses a 2-of-3 majority
//                        of rx_s taken at ticks mid-1, mid and mid+1.
//
// States
//   IDLE   | line idle, waiting for a falling edge on rx_s
//   START  | confirming the start bit at its midpoint
//   DATA   | shifting in DATA_BITS data bits, LSB first
//   PARITY | sampling and checking the parity bit
//   STOP   | sampling STOP_BITS stop bits; frame completes at last midpoint

module uart_rx_param #(
  parameter int CLK_FREQ    = 50000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 rx_valid,
  input  logic                 rx_ack,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SAMP_W   = $clog2(OVERSAMPLE + 1);
  localparam int BIDX_W   = $clog2(DATA_BITS);

  localparam logic [TICK_W-1:0] TICK_RELOAD = TICK_W'((TICK_DIV > 0) ? TICK_DIV - 1 : 0);
  localparam logic [SAMP_W-1:0] MID_START   = SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [SAMP_W-1:0] MID_BIT     = SAMP_W'(OVERSAMPLE - 1);
  localparam logic [BIDX_W-1:0] LAST_BIT    = BIDX_W'(DATA_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  generate
    if (TICK_DIV < 1) begin : g_bad_tick_div
      $error("uart_rx_param: CLK_FREQ / (BAUD_RATE * OVERSAMPLE) must be >= 1");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("uart_rx_param: DATA_BITS must be in 5..9");
    end
    if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
      $error("uart_rx_param: PARITY_MODE must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
      $error("uart_rx_param: STOP_BITS must be 1 or 2");
    end
    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
      $error("uart_rx_param: OVERSAMPLE must be even and >= 8");
    end
  endgenerate

  logic                 rx_meta;
  logic                 rx_s;
  logic                 rx_s_d;
  logic [TICK_W-1:0]    tick_cnt;
  logic                 tick;
  logic [2:0]           state;
  logic [SAMP_W-1:0]    samp_cnt;
  logic [SAMP_W-1:0]    mid_tgt;
  logic [SAMP_W-1:0]    samp_restart;
  logic [BIDX_W-1:0]    bit_idx;
  logic                 stop_idx;
  logic                 stop_last;
  logic [DATA_BITS-1:0] shreg;
  logic                 perr;
  logic                 ferr;
  logic                 ferr_final;
  logic                 par_exp;
  logic                 sample_now;
  logic                 bit_val;
  logic                 frame_done;

  // Input synchroniser plus one extra stage for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  assign tick = (tick_cnt == '0);

`ifdef UART_RX_MAJORITY_EN
  logic s_early;
  logic s_mid;

  // Capture the two samples preceding the decision tick (mid-1 and mid).
  always_ff @(posedge clk) begin
    if (reset) begin
      s_early <= 1'b1;
      s_mid   <= 1'b1;
    end else if (state != ST_IDLE && tick) begin
      if (samp_cnt == mid_tgt - SAMP_W'(1)) s_early <= rx_s;
      if (samp_cnt == mid_tgt)              s_mid   <= rx_s;
    end
  end
`endif

  always_comb begin
    mid_tgt = (state == ST_START) ? MID_START : MID_BIT;
`ifdef UART_RX_MAJORITY_EN
    // Decide one tick after mid; restart at 1 so the next midpoint keeps
    // its spacing of OVERSAMPLE ticks from this one.
    sample_now   = tick && (samp_cnt == mid_tgt + SAMP_W'(1));
    bit_val      = (s_early & s_mid) | (s_early & rx_s) | (s_mid & rx_s);
    samp_restart = SAMP_W'(1);
`else
    sample_now   = tick && (samp_cnt == mid_tgt);
    bit_val      = rx_s;
    samp_restart = '0;
`endif
  end

  assign stop_last  = (STOP_BITS == 1) || stop_idx;
  assign ferr_final = ferr | ~bit_val;
  assign par_exp    = (^shreg) ^ (PARITY_MODE == 2);
  assign frame_done = (state == ST_STOP) && sample_now && stop_last;
  assign busy       = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      tick_cnt <= TICK_RELOAD;
      samp_cnt <= '0;
      bit_idx  <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      perr     <= 1'b0;
      ferr     <= 1'b0;
    end else if (state == ST_IDLE) begin
      // Hold the tick phase and sample count cleared so both restart
      // aligned to the falling edge of the start bit.
      tick_cnt <= TICK_RELOAD;
      samp_cnt <= '0;
      if (rx_s_d && !rx_s) state <= ST_START;
    end else begin
      tick_cnt <= tick ? TICK_RELOAD : tick_cnt - TICK_W'(1);
      if (tick) samp_cnt <= sample_now ? samp_restart : samp_cnt + SAMP_W'(1);

      if (sample_now) begin
        case (state)
          ST_START: begin
            if (bit_val) begin
              state <= ST_IDLE;
            end else begin
              state    <= ST_DATA;
              bit_idx  <= '0;
              stop_idx <= 1'b0;
              shreg    <= '0;
              perr     <= 1'b0;
              ferr     <= 1'b0;
            end
          end
          ST_DATA: begin
            shreg <= {bit_val, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_BIT) state <= (PARITY_MODE != 0) ? ST_PARITY : ST_STOP;
            else                     bit_idx <= bit_idx + BIDX_W'(1);
          end
          ST_PARITY: begin
            perr  <= bit_val ^ par_exp;
            state <= ST_STOP;
          end
          ST_STOP: begin
            ferr <= ferr_final;
            if (stop_last) state    <= ST_IDLE;
            else           stop_idx <= 1'b1;
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Output holding register: a completing frame loads if the slot is free or
  // being freed this cycle, otherwise it is dropped and flagged as overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      data          <= '0;
      rx_valid      <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
    end else if (frame_done) begin
      if (!rx_valid || rx_ack) begin
        data          <= shreg;
        parity_error  <= perr;
        framing_error <= ferr_final;
        rx_valid      <= 1'b1;
      end else begin
        overrun_error <= 1'b1;
      end
    end else if (rx_valid && rx_ack) begin
      rx_valid <= 1'b0;
    end
  end

endmodule
